// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  // One register-file write request: target file, destination index, data.
  typedef struct packed {
    logic                 is_fp;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  // Pending scoreboard, bit index is {is_fp, rd}: int x0..x31 then fp f0..f31.
  typedef logic [63:0] pend_t;

  function automatic logic [5:0] pend_idx(input logic is_fp, input logic [REG_IDX_W-1:0] rd);
    return {is_fp, rd};
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small FIFO holding long-latency results until they win the write port.
// Latency: push visible at head the cycle after the push edge; head is combinational.
// Backpressure: caller must not push when full nor pop when empty (both are ignored).
// Ports: clk, rst (sync, active-high), push/push_data, pop, head, full, empty, count.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  output wb_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RF write port between pipeline writeback and buffered long-latency results.
// Latency: 0 cycles (write port combinational from granted source); long-latency results wait in FIFO.
// Backpressure: wb_ready drops only when a starved FIFO head preempts; ll_ready = FIFO not full.
// Ports: wb_* pipeline request, ll_* long-latency result, iss_* pending-set, chk_* hazard query,
//        int_wen/fp_wen/rd_idx/wr_data register-file write port, hazard to issue stage.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic            wb_is_fp,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic            ll_is_fp,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  input  logic            iss_valid,
  input  logic            iss_is_fp,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1_idx,
  input  logic [4:0]      chk_rs2_idx,
  input  logic [4:0]      chk_rd_idx,
  input  logic            chk_rs1_fp,
  input  logic            chk_rs2_fp,
  input  logic            chk_rd_fp,
  input  logic            chk_rs1_en,
  input  logic            chk_rs2_en,
  input  logic            chk_rd_en,
  output logic            hazard,
  output logic            int_wen,
  output logic            fp_wen,
  output logic [4:0]      rd_idx,
  output logic [XLEN-1:0] wr_data
);

  localparam int AGE_W = $clog2(STARVE_MAX + 1);
  localparam int CW    = $clog2(DEPTH + 1);

  wb_req_t          ll_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             fifo_push;
  logic             ll_avail;
  logic [AGE_W-1:0] age;
  logic             starve;
  logic             grant_ll;
  logic             grant_wb;
  pend_t            pending;
  pend_t            pend_set;
  pend_t            pend_clr;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ('{is_fp: ll_is_fp, rd: ll_rd, data: ll_data}),
    .pop       (grant_ll),
    .head      (ll_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ll_avail  = (fifo_count != '0);
  assign starve    = ll_avail && (age >= AGE_W'(STARVE_MAX));
  assign wb_ready  = !rst && !starve;
  assign ll_ready  = !rst && !fifo_full;
  // Gating on !full also forbids push+pop while full.
  assign fifo_push = ll_valid && ll_ready;

  always_comb begin
    grant_ll = 1'b0;
    grant_wb = 1'b0;
    if (!rst) begin
      if (starve)        grant_ll = 1'b1;
      else if (wb_valid) grant_wb = 1'b1;
      else if (ll_avail) grant_ll = 1'b1;
    end
  end

  // rd=0 writes pass through untouched; the register file discards them.
  always_comb begin
    int_wen = 1'b0;
    fp_wen  = 1'b0;
    rd_idx  = '0;
    wr_data = '0;
    if (grant_ll) begin
      int_wen = !ll_head.is_fp;
      fp_wen  = ll_head.is_fp;
      rd_idx  = ll_head.rd;
      wr_data = ll_head.data;
    end else if (grant_wb) begin
      int_wen = !wb_is_fp;
      fp_wen  = wb_is_fp;
      rd_idx  = wb_rd;
      wr_data = wb_data;
    end
  end

  // Age of the current FIFO head; a pop restarts the count for the next head.
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if (grant_ll || fifo_empty) begin
      age <= '0;
    end else if (age < AGE_W'(STARVE_MAX)) begin
      age <= age + 1'b1;
    end
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (grant_ll) pend_clr[pend_idx(ll_head.is_fp, ll_head.rd)] = 1'b1;
    if (iss_valid && (iss_rd != '0)) pend_set[pend_idx(iss_is_fp, iss_rd)] = 1'b1;
  end

  // Set applied after clear so a re-issue in the retire cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~pend_clr) | pend_set;
  end

  function automatic logic op_hazard(input pend_t p, input logic en, input logic fp,
                                     input logic [4:0] idx);
    return en && (idx != '0) && p[pend_idx(fp, idx)];
  endfunction

  // Registered bits only: a clear this cycle is not bypassed to the issue stage.
  assign hazard = !rst && (op_hazard(pending, chk_rs1_en, chk_rs1_fp, chk_rs1_idx) ||
                           op_hazard(pending, chk_rs2_en, chk_rs2_fp, chk_rs2_idx) ||
                           op_hazard(pending, chk_rd_en,  chk_rd_fp,  chk_rd_idx));

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (int_wen/fp_wen, rd_idx, wr_data) between two requesters: the in-order pipeline writeback and the long-latency unit (FP div/sqrt, multi-cycle load return).
- Buffers long-latency results in a small FIFO and prevents their starvation.
- Keeps a 64-bit pending scoreboard (32 int + 32 fp) so issue logic can stall on RAW/WAW hazards against in-flight long-latency destinations.

Parameters:
- XLEN, 32, data width.
- DEPTH, 2, long-latency result FIFO entries (power of 2, ≥2).
- STARVE_MAX, 4, cycles a FIFO head may wait before it preempts the pipeline.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_valid  in  1  pipeline writeback request
- wb_ready  out  1  pipeline writeback accepted this cycle
- wb_is_fp  in  1  target fp file
- wb_rd  in  5  destination index
- wb_data  in  XLEN  write data
- ll_valid  in  1  long-latency result valid
- ll_ready  out  1  FIFO can accept
- ll_is_fp  in  1  target fp file
- ll_rd  in  5  destination index
- ll_data  in  XLEN  result data
- iss_valid  in  1  long-latency op issued; mark rd pending
- iss_is_fp  in  1  pending file select
- iss_rd  in  5  pending index
- chk_rs1_idx / chk_rs2_idx / chk_rd_idx  in  5 each  issue-stage operand indices
- chk_rs1_fp / chk_rs2_fp / chk_rd_fp  in  1 each  operand file selects
- chk_rs1_en / chk_rs2_en / chk_rd_en  in  1 each  operand used
- hazard  out  1  any enabled operand pending
- int_wen, fp_wen  out  1 each  to register file
- rd_idx  out  5  to register file
- wr_data  out  XLEN  to register file

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, pending bits cleared, age counter cleared.
- While rst=1: int_wen=fp_wen=0, rd_idx=0, wr_data=0, wb_ready=0, ll_ready=0, hazard=0.
- Grant (combinational, per cycle), in priority order:
  1. FIFO non-empty and age≥STARVE_MAX → FIFO head; wb_ready=0.
  2. Else wb_valid → pipeline; wb_ready=1.
  3. Else FIFO non-empty → FIFO head.
  4. Else no write.
- wb_ready=1 whenever rule 1 is not in force, including when wb_valid=0.
- On a stalled cycle the pipeline must hold wb_* stable.
- Write port outputs are combinational from the granted source; the RF commits at the next edge (0-cycle arbiter latency).
- wen/rd/data are passed unchanged for rd=0; the RF drops them. Such writes still consume the grant.
- ll_ready = !full. Push when ll_valid&&ll_ready. Pop when FIFO granted.
- Simultaneous push and pop while full is not allowed (ll_ready=0).
- Push and pop in the same cycle with count 1..DEPTH-1: count unchanged.
- Read and write pointers wrap modulo DEPTH.
- Age counter:
  - Cleared on pop or when the FIFO is empty.
  - Otherwise increments each cycle; saturates at STARVE_MAX.
  - After a pop, the new head starts at age 0.
- Scoreboard:
  - iss_valid with iss_rd≠0 sets pending[iss_is_fp][iss_rd] at the edge.
  - A FIFO-granted write clears pending[head.is_fp][head.rd].
  - Same-cycle set and clear of the same bit → set wins.
  - Pipeline (wb) writes never touch pending bits.
- hazard = OR over enabled operands of pending[fp][idx], using registered bits only (no same-cycle clear bypass).
- An operand with index 0 never hazards.

Decomposition:
- Package rf_pkg holds:
  - XLEN and REG_IDX_W=5.
  - Typedef wb_req_t {logic is_fp; logic [4:0] rd; logic [XLEN-1:0] data;}.
  - Typedef pend_t = logic [63:0], indexed {is_fp, rd}.
- Sub-module rf_wb_fifo (wb_req_t entries, DEPTH, push/pop/full/empty/count, synchronous rst) instantiated once.
- Grant, age counter and scoreboard stay in the top module.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, f5 pending, rst for 1 cycle → next cycle all outputs 0, ll_ready=1 after deassert, hazard=0 for chk_rs1=f5.
- Idle port: wb_valid=1, int x3=0xDEADBEEF, FIFO empty → same cycle int_wen=1, rd_idx=3, wr_data=0xDEADBEEF, wb_ready=1.
- Starvation preemption: issue f7; push ll f7=0x3F800000; hold wb_valid=1 continuously → wb_ready=1 for 4 cycles, then one cycle with wb_ready=0, fp_wen=1, rd_idx=7. Following cycle: hazard on chk_rs1=f7 deasserts.
- FIFO full: push 2 ll results while wb_valid=1 every cycle → ll_ready=0 with count=2. Entries retire in push order via preemption; no data loss.
- Set/clear collision: FIFO head int x9 granted in the same cycle as iss_valid for x9 → pending[x9] remains 1, hazard asserted next cycle.
- Zero index: iss_rd=0 and chk_rs1_idx=0 enabled → hazard stays 0. An ll result to x0 is popped with int_wen=1, rd_idx=0.
